// File: rtl/tiger_fetch_ctrl_pkg.sv
// Tiger fetch sequencer: shared state encodings and constants.
// Imported by the fetch controller and its testbench.
package tiger_fetch_ctrl_pkg;

    localparam logic [1:0] FS_IDLE  = 2'd0;
    localparam logic [1:0] FS_ISSUE = 2'd1;
    localparam logic [1:0] FS_WAIT  = 2'd2;
    localparam logic [1:0] FS_HOLD  = 2'd3;

    localparam logic [31:0] TIGER_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TIGER_NOP          = 32'h0000_0000;

endpackage

// File: rtl/tiger_fetch_ctrl_if.sv
// Avalon-style instruction memory read port for the Tiger fetch stage.
// master = fetch controller, slave = instruction memory.
interface tiger_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);

    logic [ADDR_W-1:0] imemAddr;
    logic              imemRead;
    logic              imemWaitRequest;
    logic [31:0]       imemReadData;
    logic              imemReadDataValid;

    modport master (
        output imemAddr,
        output imemRead,
        input  imemWaitRequest,
        input  imemReadData,
        input  imemReadDataValid
    );

    modport slave (
        input  imemAddr,
        input  imemRead,
        output imemWaitRequest,
        output imemReadData,
        output imemReadDataValid
    );

endinterface

// File: rtl/tiger_fetch_ctrl.sv
// Tiger fetch sequencer: owns the PC, issues one read at a time to
// instruction memory and feeds the fetch pipeline register.
module tiger_fetch_ctrl
    import tiger_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(TIGER_RESET_VECTOR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pipeStall,
    input  logic                branchTaken,
    input  logic [ADDR_W-1:0]   branchTarget,
    tiger_fetch_ctrl_if.master  imem,
    output logic                fetchStall,
    output logic                fetchClear,
    output logic [31:0]         instrOut,
    output logic [ADDR_W-1:0]   pcOut
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              redir_q, redir_d;
    logic              squash_q, squash_d;
    logic [31:0]       hold_q, hold_d;

    logic              redirect;
    logic              accept;
    logic              rsp;
    logic              fresh;
    logic              deliver;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] pc_inc;

    assign redirect = branchTaken & ~pipeStall;
    assign br_pc    = branchTarget & ~ADDR_W'(3);
    assign pc_inc   = pc_q + ADDR_W'(4);
    assign rsp      = imem.imemReadDataValid;
    assign accept   = (state_q == FS_ISSUE) & ~imem.imemWaitRequest;
    assign fresh    = (state_q == FS_WAIT) & rsp & ~squash_q;
    assign deliver  = ~pipeStall & ~branchTaken
                    & (fresh | (state_q == FS_HOLD));

    assign imem.imemAddr = pc_q;
    assign imem.imemRead = ~reset & (state_q == FS_ISSUE);

    assign fetchStall = ~reset & pipeStall;
    assign fetchClear = reset | (~pipeStall & ~deliver);
    assign pcOut      = reset ? RESET_VECTOR : pc_q;

    always_comb begin
        instrOut = TIGER_NOP;
        if (!reset && deliver) begin
            instrOut = (state_q == FS_HOLD) ? hold_q
                                            : imem.imemReadData;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        redir_d  = redir_q;
        squash_d = squash_q;
        hold_d   = hold_q;
        // a stale response is consumed wherever it lands
        if (squash_q && rsp) begin
            squash_d = 1'b0;
        end
        unique case (state_q)
            FS_IDLE: begin
                state_d = FS_ISSUE;
                if (redirect) begin
                    pc_d = br_pc;
                end
            end
            FS_ISSUE: begin
                if (redirect) begin
                    tgt_d   = br_pc;
                    redir_d = 1'b1;
                end
                if (accept) begin
                    state_d = FS_WAIT;
                    if (redirect) begin
                        pc_d     = br_pc;
                        squash_d = 1'b1;
                        redir_d  = 1'b0;
                    end else if (redir_q) begin
                        pc_d     = tgt_q;
                        squash_d = 1'b1;
                        redir_d  = 1'b0;
                    end
                end
            end
            FS_WAIT: begin
                if (redirect) begin
                    pc_d = br_pc;
                    if (rsp) begin
                        state_d  = FS_ISSUE;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (rsp) begin
                    if (squash_q) begin
                        state_d = FS_ISSUE;
                    end else if (pipeStall) begin
                        hold_d  = imem.imemReadData;
                        state_d = FS_HOLD;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = FS_ISSUE;
                    end
                end
            end
            FS_HOLD: begin
                if (redirect) begin
                    pc_d    = br_pc;
                    hold_d  = TIGER_NOP;
                    state_d = FS_ISSUE;
                end else if (!pipeStall) begin
                    pc_d    = pc_inc;
                    state_d = FS_ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FS_IDLE;
            pc_q     <= RESET_VECTOR;
            tgt_q    <= RESET_VECTOR;
            redir_q  <= 1'b0;
            hold_q   <= TIGER_NOP;
            squash_q <= ((state_q == FS_WAIT) | squash_q) & ~rsp;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            redir_q  <= redir_d;
            hold_q   <= hold_d;
            squash_q <= squash_d;
        end
    end

endmodule

// File: tb/tb_tiger_fetch_ctrl.sv
// Bench for tiger_fetch_ctrl: directed scenarios plus a randomized run
// checked against a program-order scoreboard and a memory model.
module tb_tiger_fetch_ctrl;

    localparam int          AW = 32;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipeStall;
    logic          branchTaken;
    logic [AW-1:0] branchTarget;
    logic          fetchStall;
    logic          fetchClear;
    logic [31:0]   instrOut;
    logic [AW-1:0] pcOut;

    tiger_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    tiger_fetch_ctrl #(
        .ADDR_W      (AW),
        .RESET_VECTOR(RV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipeStall   (pipeStall),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .imem        (bus),
        .fetchStall  (fetchStall),
        .fetchClear  (fetchClear),
        .instrOut    (instrOut),
        .pcOut       (pcOut)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    bit          mem_out = 0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = '0;
    int          lat_cfg = 0;
    bit          acc_p = 0;
    bit          v_p = 0;
    logic [31:0] addr_p = '0;
    bit          pwr = 0;
    logic [31:0] paddr = '0;
    logic [31:0] exp_pc = RV;
    int          gap = 0;
    int          ndel = 0;

    logic        s_read, s_stall, s_clr;
    logic [31:0] s_addr, s_instr, s_pc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: memory model drives the bus, outputs are sampled
    // 3ns after the inputs settle, the scoreboard checks them.
    task automatic cyc(input bit rst, input bit ps, input bit br,
                       input logic [31:0] tgt, input bit wr);
        bit v;
        bit dl;
        if (v_p) mem_out = 0;
        if (acc_p) begin
            check("one_outstanding", {31'd0, mem_out}, 32'd0);
            mem_out  = 1;
            mem_addr = addr_p;
            mem_lat  = lat_cfg;
        end
        v = mem_out && (mem_lat == 0);
        if (mem_out && mem_lat != 0) mem_lat--;
        reset                 = rst;
        pipeStall             = ps;
        branchTaken           = br;
        branchTarget          = tgt;
        bus.imemWaitRequest   = wr;
        bus.imemReadDataValid = v;
        bus.imemReadData      = v ? mem_addr : 32'hDEAD_BEEF;
        #3;
        s_read  = bus.imemRead;
        s_addr  = bus.imemAddr;
        s_stall = fetchStall;
        s_clr   = fetchClear;
        s_instr = instrOut;
        s_pc    = pcOut;
        if (rst) begin
            check("rst_read", {31'd0, s_read}, 32'd0);
            check("rst_stall", {31'd0, s_stall}, 32'd0);
            check("rst_clear", {31'd0, s_clr}, 32'd1);
            check("rst_instr", s_instr, 32'd0);
            check("rst_pc", s_pc, RV);
            exp_pc = RV;
            gap    = 0;
        end else begin
            check("stall_follows", {31'd0, s_stall}, {31'd0, ps});
            if (ps) check("no_clear_stalled", {31'd0, s_clr}, 32'd0);
            if (br && !ps) check("branch_clear", {31'd0, s_clr}, 32'd1);
            if (pwr) begin
                check("wr_read_stable", {31'd0, s_read}, 32'd1);
                check("wr_addr_stable", s_addr, paddr);
            end
            dl = !s_stall && !s_clr;
            if (dl) begin
                check("deliver_pc", s_pc, exp_pc);
                check("deliver_instr", s_instr, s_pc);
                exp_pc = exp_pc + 32'd4;
                ndel++;
            end
            if (br && !ps) exp_pc = tgt & 32'hFFFF_FFFC;
            if (dl || (br && !ps)) gap = 0;
            else if (!ps) gap++;
            check("liveness", {31'd0, gap > 40}, 32'd0);
            if (gap > 40) gap = 0;
        end
        acc_p  = s_read && !wr && !rst;
        addr_p = s_addr;
        v_p    = v;
        pwr    = s_read && wr && !rst;
        paddr  = s_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] a);
        cyc(0, 0, 0, 0, 0);
        check("issue_read", {31'd0, s_read}, 32'd1);
        check("issue_addr", s_addr, a);
        check("issue_gap_clear", {31'd0, s_clr}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("fetch_instr", s_instr, a);
        check("fetch_pc", s_pc, a);
        check("fetch_clear", {31'd0, s_clr}, 32'd0);
    endtask

    initial begin
        bit rr;
        reset                 = 1;
        pipeStall             = 0;
        branchTaken           = 0;
        branchTarget          = '0;
        bus.imemWaitRequest   = 0;
        bus.imemReadDataValid = 0;
        bus.imemReadData      = '0;
        @(posedge clk);
        #1;
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("idle_read", {31'd0, s_read}, 32'd0);
        check("idle_clear", {31'd0, s_clr}, 32'd1);
        for (int a = 0; a < 'h10; a += 4) fetch_one(a);

        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, k < 3);
            check("wait_read", {31'd0, s_read}, 32'd1);
            check("wait_addr", s_addr, 32'h10);
        end
        cyc(0, 0, 0, 0, 0);
        check("wait_deliver", s_instr, 32'h10);
        for (int a = 'h14; a < 'h20; a += 4) fetch_one(a);

        cyc(0, 0, 0, 0, 0);
        check("hold_issue", s_addr, 32'h20);
        cyc(0, 1, 0, 0, 0);
        check("hold_enter_stall", {31'd0, s_stall}, 32'd1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check("hold_stall", {31'd0, s_stall}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("hold_release_instr", s_instr, 32'h20);
        check("hold_release_clear", {31'd0, s_clr}, 32'd0);
        for (int a = 'h24; a < 'h40; a += 4) fetch_one(a);

        lat_cfg = 1;
        cyc(0, 0, 0, 0, 0);
        check("br_wait_issue", s_addr, 32'h40);
        cyc(0, 0, 1, 32'h103, 0);
        check("br_wait_clear", {31'd0, s_clr}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("br_wait_discard", {31'd0, s_clr}, 32'd1);
        lat_cfg = 0;
        fetch_one(32'h100);

        cyc(0, 0, 1, 32'h200, 1);
        check("br_issue_addr", s_addr, 32'h104);
        cyc(0, 0, 0, 0, 1);
        check("br_issue_hold", s_addr, 32'h104);
        cyc(0, 0, 0, 0, 0);
        check("br_issue_accept", s_addr, 32'h104);
        cyc(0, 0, 0, 0, 0);
        check("br_issue_discard", {31'd0, s_clr}, 32'd1);
        fetch_one(32'h200);

        lat_cfg = 1;
        cyc(0, 0, 0, 0, 0);
        check("rst_wait_issue", s_addr, 32'h204);
        cyc(1, 0, 0, 0, 0);
        lat_cfg = 0;
        cyc(0, 0, 0, 0, 0);
        check("stale_ignored", {31'd0, s_clr}, 32'd1);
        fetch_one(RV);

        cyc(0, 0, 1, 32'hFFFF_FFFE, 0);
        cyc(0, 0, 0, 0, 0);
        check("wrap_discard", {31'd0, s_clr}, 32'd1);
        fetch_one(32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        check("wrap_addr", s_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            lat_cfg = $urandom_range(0, 3);
            rr = ($urandom_range(0, 199) == 0)
               && (!mem_out || v_p) && !acc_p;
            cyc(rr, $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) < 8, $urandom,
                $urandom_range(0, 9) < 3);
        end
        check("deliveries", {31'd0, ndel > 300}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
